edge_synth: RTL and testbench
=============================

Name: edge_synth

Overview:
- Inverse of the edge detector: turns one-cycle rise/fall request pulses into a clean level.
- Enforces a minimum stable time after every transition.
- Buffers one request that arrives during the hold window.
- Reports a dropped or collided request with a one-cycle pulse.

Parameters:
- MIN_HOLD, 4, minimum number of cycles level_o stays stable after a transition. Legal range ≥1.
- RESET_LEVEL, 1'b0, value of level_o during and after reset.
- CNT_W, $clog2(MIN_HOLD+1), hold counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- rise_i  input  1  request that level_o go high; one-cycle pulse
- fall_i  input  1  request that level_o go low; one-cycle pulse
- level_o  output  1  registered synthesized level
- rising_edge_o  output  1  high in the first cycle of level_o==1 after a 0→1 transition
- falling_edge_o  output  1  high in the first cycle of level_o==0 after a 1→0 transition
- busy_o  output  1  hold window active; a transition is not allowed this cycle
- pending_o  output  1  one buffered request is waiting
- drop_o  output  1  one-cycle pulse: a request was discarded

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values, applied immediately and held until release:
  - level_o = RESET_LEVEL
  - rising_edge_o, falling_edge_o, busy_o, pending_o, drop_o all 0
  - hold counter = 0; pending register cleared
- States:
  - IDLE: counter == 0.
  - HOLD: counter != 0.
  - busy_o = (state == HOLD).
- Request decode, each cycle:
  - req = rise_i XOR fall_i.
  - dir = rise_i.
  - rise_i && fall_i together is a collision. Both requests are ignored, drop_o pulses next cycle, pending register unchanged.
- IDLE:
  - Valid req with dir != level_o: level_o <= dir. Matching edge pulse next cycle. Counter <= MIN_HOLD-1. Latency is 1 cycle from the request edge to the level change.
  - Valid req with dir == level_o (redundant): ignored silently, no drop_o.
- HOLD, counter decrements each cycle:
  - Valid req with dir != level_o: stored in the pending register, pending_o=1. If a pending request already exists with the same dir, no drop.
  - Valid req with dir == level_o while a pending request (opposite dir) exists: the requests cancel. Pending cleared, drop_o pulses.
  - Valid req with dir == level_o and nothing pending: ignored silently.
- Hold expiry (counter == 1 → 0):
  - Pending request, or a new request in the same cycle, is applied so that level_o changes exactly MIN_HOLD cycles after the previous change.
  - A new request in the expiry cycle has priority over the pending one (latest wins).
  - If the new request overrides a pending request of the opposite dir, drop_o pulses.
  - Pending is cleared on application.
- Back-to-back transitions: two level changes are never closer than MIN_HOLD cycles.
- MIN_HOLD == 1:
  - The counter always stays 0 and busy_o never asserts.
  - Every valid non-redundant request is applied the next cycle; pending_o never asserts.
- Pulses: rising_edge_o, falling_edge_o and drop_o are single-cycle and registered. rising_edge_o and falling_edge_o are mutually exclusive.
- Reset mid-operation:
  - Hold aborts, pending is discarded, level_o is forced to RESET_LEVEL.
  - No edge pulse is generated for the reset-induced change.

Decomposition:
- Package edge_synth_pkg:
  - localparams DIR_FALL = 1'b0, DIR_RISE = 1'b1
  - state encoding ST_IDLE / ST_HOLD
- Sub-module hold_timer (parameter MIN_HOLD):
  - Inputs: clk, reset, load.
  - Outputs: busy, expire.
  - Loadable down-counter.
- Request arbitration and the pending register stay in edge_synth.

Test Plan (MIN_HOLD=4, RESET_LEVEL=0, edges numbered from reset release):
1. Reset held 3 cycles, then released → level_o=0, busy_o=0, pending_o=0, all pulses 0; no change for 5 idle cycles.
2. rise_i at edge 2 → level_o=1 and rising_edge_o=1 after edge 2; busy_o=1 for cycles 3–5. fall_i at edge 3 → pending_o=1. level_o=0 and falling_edge_o=1 after edge 6; pending_o=0.
3. rise_i at edge 2, fall_i at edge 3, rise_i at edge 4 → drop_o=1 after edge 4, pending_o=0, level_o stays 1 through edge 10.
4. rise_i and fall_i together at edge 2 in IDLE → drop_o=1 for one cycle, level_o=0, busy_o=0.
5. rise_i at edge 2, then rise_i again at edge 8 (idle, already high) → no level change, no pulses, drop_o=0.
6. rise_i at edge 2, fall_i at edge 3 (pending), reset asserted at edge 4 for 2 cycles → level_o=0 immediately, pending_o=0, no falling_edge_o. After release, rise_i → level_o=1 the next cycle.

Source files
------------

// File: rtl/edge_synth_pkg.sv
// edge_synth_pkg: shared definitions for the edge synthesizer.
//   DIR_FALL / DIR_RISE : encoding of a request direction (the level it asks for)
//   state_e             : IDLE (no hold window) / HOLD (hold window running)
package edge_synth_pkg;

  localparam logic DIR_FALL = 1'b0;
  localparam logic DIR_RISE = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/edge_synth_if.sv
// edge_synth_if: request/level bundle of the edge synthesizer.
//   rise_i, fall_i   : one-cycle request pulses (driven by master)
//   level_o          : synthesized level
//   rising_edge_o    : first cycle of level_o==1 after a 0->1 change
//   falling_edge_o   : first cycle of level_o==0 after a 1->0 change
//   busy_o           : hold window active
//   pending_o        : one buffered request waiting
//   drop_o           : one-cycle pulse, a request was discarded
interface edge_synth_if;

  logic rise_i;
  logic fall_i;
  logic level_o;
  logic rising_edge_o;
  logic falling_edge_o;
  logic busy_o;
  logic pending_o;
  logic drop_o;

  modport master (
    output rise_i,
    output fall_i,
    input  level_o,
    input  rising_edge_o,
    input  falling_edge_o,
    input  busy_o,
    input  pending_o,
    input  drop_o
  );

  modport slave (
    input  rise_i,
    input  fall_i,
    output level_o,
    output rising_edge_o,
    output falling_edge_o,
    output busy_o,
    output pending_o,
    output drop_o
  );

endinterface

// File: rtl/edge_synth_hold_timer.sv
// edge_synth_hold_timer: loadable down-counter timing the hold window.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   load   : a level change happens at this edge; restart the window
//   busy   : window active (counter != 0)
//   expire : one-cycle pulse in the first idle cycle after a window ends
module edge_synth_hold_timer #(
  parameter int unsigned MIN_HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(MIN_HOLD + 1);
  // The change cycle itself counts as the first stable cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MIN_HOLD - 1);

  logic [CNT_W-1:0] count_q;
  logic             expire_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      expire_q <= 1'b0;
      if (load) begin
        count_q <= LOAD_VAL;
      end else if (count_q != '0) begin
        count_q  <= count_q - 1'b1;
        expire_q <= (count_q == CNT_W'(1));
      end
    end
  end

  assign busy   = (count_q != '0);
  assign expire = expire_q;

endmodule

// File: rtl/edge_synth.sv
// edge_synth: turns rise/fall request pulses into a clean level with a
// minimum stable time after every transition.
//   clk   : system clock, rising-edge active
//   reset : asynchronous active-high reset
//   bus   : edge_synth_if.slave (requests in; level, edge pulses, busy,
//           pending and drop out)
// A request that arrives inside the hold window is buffered and applied in
// the first idle cycle, so the level changes exactly MIN_HOLD cycles after
// the previous change.
module edge_synth
  import edge_synth_pkg::*;
#(
  parameter int unsigned MIN_HOLD    = 4,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input logic         clk,
  input logic         reset,
  edge_synth_if.slave bus
);

  state_e state;
  logic   busy;
  logic   expire;

  logic level_q;
  logic rising_q;
  logic falling_q;
  logic drop_q;
  logic pending_q;
  logic pend_dir_q;

  logic req;
  logic dir;
  logic collide;
  logic apply;
  logic apply_dir;
  logic pending_d;
  logic pend_dir_d;
  logic drop_d;

  edge_synth_hold_timer #(
    .MIN_HOLD(MIN_HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .load  (apply),
    .busy  (busy),
    .expire(expire)
  );

  always_comb begin
    collide    = bus.rise_i & bus.fall_i;
    req        = bus.rise_i ^ bus.fall_i;
    dir        = bus.rise_i ? DIR_RISE : DIR_FALL;
    state      = busy ? ST_HOLD : ST_IDLE;
    apply      = 1'b0;
    apply_dir  = level_q;
    pending_d  = pending_q;
    pend_dir_d = pend_dir_q;
    // A collision is ignored as a request but always reported.
    drop_d     = collide;
    unique case (state)
      ST_IDLE: begin
        if (req && (dir != level_q)) begin
          // Latest request wins; a pending one here has the same dir.
          apply     = 1'b1;
          apply_dir = dir;
        end else if (req && pending_q) begin
          // Redundant request overrides the opposite pending one.
          drop_d = 1'b1;
        end else if (pending_q && expire) begin
          apply     = 1'b1;
          apply_dir = pend_dir_q;
        end
        pending_d = 1'b0;
      end
      ST_HOLD: begin
        if (req && (dir != level_q)) begin
          pending_d  = 1'b1;
          pend_dir_d = dir;
        end else if (req && pending_q) begin
          // Opposite requests inside the window cancel out.
          pending_d = 1'b0;
          drop_d    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q    <= RESET_LEVEL;
      rising_q   <= 1'b0;
      falling_q  <= 1'b0;
      drop_q     <= 1'b0;
      pending_q  <= 1'b0;
      pend_dir_q <= DIR_FALL;
    end else begin
      if (apply) begin
        level_q <= apply_dir;
      end
      rising_q   <= apply && (apply_dir == DIR_RISE);
      falling_q  <= apply && (apply_dir == DIR_FALL);
      drop_q     <= drop_d;
      pending_q  <= pending_d;
      pend_dir_q <= pend_dir_d;
    end
  end

  assign bus.level_o        = level_q;
  assign bus.rising_edge_o  = rising_q;
  assign bus.falling_edge_o = falling_q;
  assign bus.busy_o         = (state == ST_HOLD);
  assign bus.pending_o      = pending_q;
  assign bus.drop_o         = drop_q;

endmodule

// File: tb/tb_edge_synth.sv
// tb_edge_synth: table-driven scoreboard bench for edge_synth.
// u_dut: MIN_HOLD=4, RESET_LEVEL=0; u_dut1: MIN_HOLD=1, RESET_LEVEL=1.
// Output vectors are packed as {level, rising, falling, busy, pending, drop}.
module tb_edge_synth;

  typedef struct packed {
    logic       rise;
    logic       fall;
    logic [5:0] exp;
  } vec_t;

  localparam logic [5:0] L = 6'b100000;
  localparam logic [5:0] R = 6'b010000;
  localparam logic [5:0] F = 6'b001000;
  localparam logic [5:0] B = 6'b000100;
  localparam logic [5:0] P = 6'b000010;
  localparam logic [5:0] D = 6'b000001;
  localparam logic [5:0] Z = 6'b000000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  edge_synth_if bus0 ();
  edge_synth_if bus1 ();

  edge_synth #(
    .MIN_HOLD   (4),
    .RESET_LEVEL(1'b0)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  edge_synth #(
    .MIN_HOLD   (1),
    .RESET_LEVEL(1'b1)
  ) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  logic [5:0] exp_q[$];

  function automatic logic [5:0] got0();
    return {bus0.level_o, bus0.rising_edge_o, bus0.falling_edge_o,
            bus0.busy_o, bus0.pending_o, bus0.drop_o};
  endfunction

  function automatic logic [5:0] got1();
    return {bus1.level_o, bus1.rising_edge_o, bus1.falling_edge_o,
            bus1.busy_o, bus1.pending_o, bus1.drop_o};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (level,rise,fall,busy,pend,drop)", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic [5:0] e);
    tbl.push_back({r, f, e});
  endtask

  // Drive one request pattern, predict, clock, then compare the popped expectation.
  task automatic run_row(input string name, input int dut, input vec_t v);
    logic [5:0] e;
    if (dut == 0) begin
      bus0.rise_i = v.rise;
      bus0.fall_i = v.fall;
    end else begin
      bus1.rise_i = v.rise;
      bus1.fall_i = v.fall;
    end
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    bus0.rise_i = 1'b0;
    bus0.fall_i = 1'b0;
    bus1.rise_i = 1'b0;
    bus1.fall_i = 1'b0;
    e = exp_q.pop_front();
    check(name, (dut == 0) ? got0() : got1(), e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus0.rise_i = 1'b0;
    bus0.fall_i = 1'b0;
    bus1.rise_i = 1'b0;
    bus1.fall_i = 1'b0;

    // 1: reset state and idle
    repeat (5) add(0, 0, Z);
    // 2: rise, fall buffered during hold, applied MIN_HOLD after the rise
    add(1, 0, L | R | B);
    add(0, 1, L | B | P);
    add(0, 0, L | B | P);
    add(0, 0, L | P);
    add(0, 0, F | B);
    add(0, 0, B);
    add(0, 0, B);
    add(0, 0, Z);
    // 3: rise, fall, rise cancels the pending fall
    add(1, 0, L | R | B);
    add(0, 1, L | B | P);
    add(1, 0, L | B | D);
    repeat (6) add(0, 0, L);
    add(0, 1, F | B);
    add(0, 0, B);
    add(0, 0, B);
    add(0, 0, Z);
    // 4: collision in idle
    add(1, 1, D);
    add(0, 0, Z);
    // 5: redundant rise while idle and high
    add(1, 0, L | R | B);
    add(0, 0, L | B);
    add(0, 0, L | B);
    repeat (3) add(0, 0, L);
    add(1, 0, L);
    // new request in the expiry cycle overrides an opposite pending one
    add(0, 1, F | B);
    add(1, 0, B | P);
    add(0, 0, B | P);
    add(0, 0, P);
    add(0, 1, D);
    add(0, 0, Z);
    // collision inside hold leaves the pending request intact
    add(1, 0, L | R | B);
    add(0, 1, L | B | P);
    add(1, 1, L | B | P | D);
    add(0, 0, L | P);
    add(0, 0, F | B);
    add(0, 0, B);
    add(0, 0, B);
    add(0, 0, Z);

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold0", got0(), Z);
    check("reset_hold1", got1(), L);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run_row($sformatf("row%0d", i), 0, tbl[i]);
    end

    // MIN_HOLD=1: every non-redundant request applies next cycle, never busy
    run_row("mh1_fall", 1, {1'b0, 1'b1, F});
    run_row("mh1_rise", 1, {1'b1, 1'b0, L | R});
    run_row("mh1_fall2", 1, {1'b0, 1'b1, F});
    run_row("mh1_idle", 1, {1'b0, 1'b0, Z});
    run_row("mh1_collide", 1, {1'b1, 1'b1, D});
    run_row("mh1_redundant", 1, {1'b0, 1'b1, Z});
    run_row("mh1_rise2", 1, {1'b1, 1'b0, L | R});
    run_row("mh1_idle2", 1, {1'b0, 1'b0, L});

    // 6: reset in the middle of a hold with a pending fall
    run_row("rst_rise", 0, {1'b1, 1'b0, L | R | B});
    run_row("rst_fall", 0, {1'b0, 1'b1, L | B | P});
    reset = 1'b1;
    #2;
    check("rst_async", got0(), Z);
    @(posedge clk);
    #1;
    check("rst_cyc1", got0(), Z);
    @(posedge clk);
    #1;
    check("rst_cyc2", got0(), Z);
    reset = 1'b0;
    run_row("rst_after_idle", 0, {1'b0, 1'b0, Z});
    run_row("rst_after_rise", 0, {1'b1, 1'b0, L | R | B});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
